// File: rtl/ram_burst.sv
// ram_burst: command-driven single-port RAM slave with auto-increment writes and read bursts.
// Optional macro RAM_CLEAR_EN: zero the whole memory after reset release. Rev 1.0
`default_nettype none

module ram_burst #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int MAX_BURST_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              busy,
    output logic              drop
);

    localparam int MEM_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]      ADDR_ONE = 1;
    localparam logic [MAX_BURST_W-1:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t                 state;
    logic [DATA_W-1:0]      mem [MEM_DEPTH];
    logic [ADDR_W-1:0]      addr_w;
    logic [ADDR_W-1:0]      addr_r;
    logic [MAX_BURST_W-1:0] burst_cnt;
    logic [1:0]             cmd;
    logic [DATA_W-1:0]      payload;

    assign cmd     = din[DATA_W+1:DATA_W];
    assign payload = din[DATA_W-1:0];

`ifdef RAM_CLEAR_EN
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    logic [ADDR_W-1:0] clr_addr;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_w    <= '0;
            addr_r    <= '0;
            burst_cnt <= '0;
            dout      <= '0;
            tx_valid  <= 1'b0;
            drop      <= 1'b0;
`ifdef RAM_CLEAR_EN
            // Clear starts on the first cycle after release, so busy is already up.
            state     <= CLEAR;
            busy      <= 1'b1;
            clr_addr  <= '0;
`else
            state     <= IDLE;
            busy      <= 1'b0;
`endif
        end else begin
            tx_valid <= 1'b0;
            drop     <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        case (cmd)
                            2'b00: addr_w <= payload[ADDR_W-1:0];
                            2'b10: addr_r <= payload[ADDR_W-1:0];
                            2'b01: begin
                                mem[addr_w] <= payload;
                                addr_w      <= addr_w + ADDR_ONE;
                            end
                            default: begin
                                burst_cnt <= payload[MAX_BURST_W-1:0];
                                state     <= BURST;
                                busy      <= 1'b1;
                            end
                        endcase
                    end
                end
                BURST: begin
                    dout     <= mem[addr_r];
                    tx_valid <= 1'b1;
                    addr_r   <= addr_r + ADDR_ONE;
                    drop     <= rx_valid;
                    // burst_cnt holds words remaining after this one
                    if (burst_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        burst_cnt <= burst_cnt - CNT_ONE;
                    end
                end
`ifdef RAM_CLEAR_EN
                CLEAR: begin
                    mem[clr_addr] <= '0;
                    clr_addr      <= clr_addr + ADDR_ONE;
                    drop          <= rx_valid;
                    if (clr_addr == ADDR_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_burst.sv
// tb_ram_burst: scoreboard bench for ram_burst; expected read words queued when bursts are issued.
`default_nettype none

module tb_ram_burst;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic       busy;
    logic       drop;

    int checks = 0;
    int errors = 0;
    int run = 0;
    int last_run = 0;

    logic [7:0] m_mem [256];
    logic [7:0] m_aw = '0;
    logic [7:0] m_ar = '0;
    logic [7:0] exp_q [$];

    ram_burst #(.DATA_W(8), .ADDR_W(8), .MAX_BURST_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .busy     (busy),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output side of the scoreboard
    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            run++;
            if (exp_q.size() == 0) check("unexpected_tx", 1, 0);
            else check("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] p);
        din = {c, p};
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        case (c)
            2'b00: m_aw = p;
            2'b10: m_ar = p;
            2'b01: begin
                m_mem[m_aw] = p;
                m_aw = m_aw + 8'd1;
            end
            default: begin
                for (int i = 0; i <= int'(p[3:0]); i++) begin
                    exp_q.push_back(m_mem[m_ar]);
                    m_ar = m_ar + 8'd1;
                end
            end
        endcase
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check("wait_timeout", {31'd0, n < 300}, 1);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        exp_q.delete();
        m_aw = '0;
        m_ar = '0;
        rst_n = 1'b1;
`ifdef RAM_CLEAR_EN
        begin
            int cnt = 0;
            while (busy === 1'b1 && cnt < 400) begin
                cnt++;
                step();
            end
            check("clear_busy_cycles", cnt, 256);
            for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        end
`endif
    endtask

    initial begin
        int bcnt;

        do_reset();
        check("rst_dout", {24'd0, dout}, 0);
        check("rst_tx_valid", {31'd0, tx_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_drop", {31'd0, drop}, 0);

        // Basic write then 2-word burst
        send(2'b00, 8'h10);
        send(2'b01, 8'hA5);
        send(2'b01, 8'h5A);
        send(2'b01, 8'hC3);
        send(2'b10, 8'h10);
        send(2'b11, 8'h01);
        bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy === 1'b1) bcnt++;
            step();
        end
        check("busy_len_2", bcnt, 2);
        wait_done();
        check("run_len_2", last_run, 2);
        // addr_r must now sit at 0x12, which holds 0xC3
        send(2'b11, 8'h00);
        wait_done();

        // Write-address wrap
        send(2'b00, 8'hFF);
        send(2'b01, 8'h11);
        send(2'b01, 8'h22);
        send(2'b10, 8'hFF);
        send(2'b11, 8'h00);
        wait_done();
        send(2'b10, 8'h00);
        send(2'b11, 8'h00);
        wait_done();

        // Maximum burst across the read wrap
        send(2'b00, 8'hF8);
        for (int i = 0; i < 16; i++) send(2'b01, 8'($urandom_range(0, 255)));
        send(2'b10, 8'hF8);
        send(2'b11, 8'h0F);
        wait_done();
        check("run_len_16", last_run, 16);

        // Command during burst is dropped
        send(2'b10, 8'h00);
        send(2'b11, 8'h07);
        step();
        din = {2'b01, 8'h77};
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        check("drop_pulse", {31'd0, drop}, 1);
        step();
        check("drop_clear", {31'd0, drop}, 0);
        wait_done();
        check("run_len_8", last_run, 8);
        send(2'b01, 8'h99);
        send(2'b10, m_aw - 8'd1);
        send(2'b11, 8'h00);
        wait_done();

        // Reset mid-burst
        send(2'b10, 8'h00);
        send(2'b11, 8'h07);
        step();
        step();
        rst_n = 1'b0;
        step();
        check("midrst_tx_valid", {31'd0, tx_valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_words", exp_q.size(), 6);
        do_reset();
        send(2'b10, 8'h01);
        send(2'b11, 8'h00);
        wait_done();
        send(2'b11, 8'h02);
        wait_done();
        check("run_len_3", last_run, 3);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_burst.md
Name: ram_burst

Overview:
- Parametrised single-port command-driven RAM slave; next generation of the SPI slave's backing RAM.
- Adds configurable data/address width, write-address auto-increment and multi-word read bursts.
- Sits behind the SPI slave front end: accepts one {cmd, payload} word per rx_valid and returns read data as a tx_valid-qualified stream.

Parameters:
- DATA_W, 8, payload and memory word width; must be >= ADDR_W.
- ADDR_W, 8, address width; MEM_DEPTH = 2**ADDR_W.
- MAX_BURST_W, 4, width of the burst-length field taken from din[MAX_BURST_W-1:0]; must be <= DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- din  input  DATA_W+2  din[DATA_W+1:DATA_W] is the command; din[DATA_W-1:0] is the payload
- rx_valid  input  1  din valid this cycle
- dout  output  DATA_W  read data
- tx_valid  output  1  dout valid this cycle (one-cycle pulse per word)
- busy  output  1  burst (or clear) in progress; commands are not accepted
- drop  output  1  one-cycle pulse: rx_valid arrived while busy and the command was discarded

Behaviour:
- Clock and reset: all logic on posedge clk. Reset is synchronous and active-low on rst_n.
- Reset values: dout=0, tx_valid=0, busy=0, drop=0, addr_w=0, addr_r=0, burst counter=0, state=IDLE. Memory contents are not reset unless RAM_CLEAR_EN is defined.
- State machine: two states, IDLE and BURST.
- Commands in IDLE with rx_valid=1:
  - 00: addr_w <= payload[ADDR_W-1:0].
  - 10: addr_r <= payload[ADDR_W-1:0].
  - 01: mem[addr_w] <= payload; addr_w <= addr_w+1, wrapping modulo MEM_DEPTH.
  - 11: start a burst of L = payload[MAX_BURST_W-1:0]+1 words (1..2**MAX_BURST_W); go to BURST; busy=1 from the next cycle.
- Burst timing: a burst command accepted at cycle T produces words at T+1 .. T+L.
  - Each burst cycle: dout <= mem[addr_r], tx_valid=1, addr_r <= addr_r+1 (wrapping).
  - busy is high for cycles T+1 .. T+L.
  - Return to IDLE after the last word, so a new command is accepted at cycle T+L+1 at the earliest.
  - After the burst, addr_r points to the word after the last one read.
- Outside a burst: tx_valid=0 every cycle; dout holds its last value.
- rx_valid while busy: command discarded with no state change; drop=1 the following cycle.
- rx_valid=0: no state change. Non-command bits of din are ignored.
- Address wrap: read or write at address MEM_DEPTH-1 moves to address 0, with no flag.
- Read-after-write: a write at cycle T is visible to a burst started at T+1 or later (the burst reads at T+2 or later).
- Reset mid-burst: burst aborted; tx_valid=0 and busy=0 from the next cycle; addresses return to 0.

Optional Feature:
- Macro: RAM_CLEAR_EN.
- Defined:
  - After rst_n is released (first cycle with rst_n=1 following reset), enter a CLEAR state for MEM_DEPTH cycles, writing 0 to mem[0..MEM_DEPTH-1] one word per cycle.
  - busy=1 throughout CLEAR. rx_valid during CLEAR is dropped with a drop pulse.
  - IDLE is reached after MEM_DEPTH cycles.
  - Reasserting rst_n during CLEAR restarts the clear from address 0.
- Not defined: no CLEAR state; memory is uninitialised; IDLE immediately after reset; busy=0 after reset.

Test Plan:
- Reset then write: {00,0x10}, {01,0xA5}, {01,0x5A}, {10,0x10}, {11,0x01} -> tx_valid on 2 consecutive cycles with dout=0xA5 then 0x5A; busy high exactly 2 cycles; addr_r=0x12 afterwards.
- Write-address wrap: {00,0xFF}, {01,0x11}, {01,0x22}, then read bursts from 0xFF (length 1) and from 0x00 (length 1) -> 0x11 and 0x22.
- Maximum burst: {11,0x0F} with addr_r=0xF8 -> 16 words mem[0xF8..0xFF], mem[0x00..0x07]; tx_valid high for 16 consecutive cycles.
- Command during burst: {01,0x77} issued at burst cycle 2 -> drop pulses once; memory and addr_w unchanged; burst output uninterrupted.
- Reset mid-burst: rst_n=0 at burst word 3 of 8 -> tx_valid=0, busy=0 the next cycle; a subsequent {10,x}/{11,0} burst works normally.
- RAM_CLEAR_EN defined: after reset, busy=1 for exactly 256 cycles; then a 16-word burst from 0x00 returns all zeros; rx_valid during clear -> drop pulse.
